// File: rtl/rg_pipe.sv
// rg_pipe: DEPTH-stage N-bit register pipeline with per-stage valid/ready, bubble collapsing and flush.
// Optional occupancy output enabled by defining RG_PIPE_OCC_EN.
module rg_pipe #(
    parameter int             N         = 10,
    parameter int             DEPTH     = 4,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] o
`ifdef RG_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    logic [DEPTH-1:0]        v_q, v_d, rdy, up_v;
    logic [DEPTH-1:0][N-1:0] d_q, d_d, up_d;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_v[k] = in_valid;
            assign up_d[k] = i;
        end else begin : g_body
            assign up_v[k] = v_q[k-1];
            assign up_d[k] = d_q[k-1];
        end
        // A stage can load when the consumer takes or any stage at or beyond it is empty.
        assign rdy[k] = out_ready | (|(~v_q >> k));
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign o         = d_q[DEPTH-1];

    // Next state: load from upstream when ready, data only changes on a valid load; flush wins.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = ~flush & (rdy[k] ? up_v[k] : v_q[k]);
            d_d[k] = flush ? RESET_VAL : (rdy[k] & up_v[k]) ? up_d[k] : d_q[k];
        end
    end

    // Stage registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            d_q <= {DEPTH{RESET_VAL}};
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

`ifdef RG_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH+1);
    // Occupancy is the popcount of stage valid bits.
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) occ = occ + OW'(v_q[k]);
    end
`endif

endmodule

// File: tb/tb_rg_pipe.sv
// tb_rg_pipe: directed and random checks of rg_pipe against a queue-based reference model.
module tb_rg_pipe;
    localparam int N = 10, DEPTH = 4;

    logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [N-1:0] i = '0, o;
`ifdef RG_PIPE_OCC_EN
    logic [2:0] occ;
`endif

    int n_chk = 0, n_fail = 0;
    logic [N-1:0] q[$], outs[$];
    logic s_ov, s_acc, s_take;
    logic [N-1:0] s_o;
    int lat_ov[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    int lat_d[8]  = '{32, 0, 21, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    rg_pipe #(.N(N), .DEPTH(DEPTH), .RESET_VAL(10'd0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .i(i),
        .out_valid(out_valid), .out_ready(out_ready), .o(o)
`ifdef RG_PIPE_OCC_EN
        , .occ(occ)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, update the model after the rising edge.
    task automatic cyc(input logic iv, input logic [N-1:0] id, input logic ordy, input logic fl);
        in_valid = iv; i = id; out_ready = ordy; flush = fl;
        #4;
        s_ov = out_valid; s_o = o; s_acc = iv & in_ready; s_take = out_valid & ordy;
        chk("in_ready", in_ready, !fl && (ordy || q.size() < DEPTH));
`ifdef RG_PIPE_OCC_EN
        chk("occ", occ, q.size());
`endif
        if (q.size() == 0) chk("ov_empty", out_valid, 0);
        if (q.size() == DEPTH) chk("ov_full", out_valid, 1);
        if (s_take && q.size() > 0) chk("data", o, q[0]);
        @(posedge clk); #1;
        if (fl) q.delete();
        else begin
            if (s_take && q.size() > 0) begin
                outs.push_back(s_o);
                void'(q.pop_front());
            end
            if (s_acc) q.push_back(id);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && q.size() > 0; c++) cyc(0, '0, 1, 0);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n, cnt;
        // reset
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ov", out_valid, 0);
        chk("rst_o", o, 0);
        reset = 1;
        #1;
        chk("rel_ir", in_ready, 1);
        chk("rel_ov", out_valid, 0);
`ifdef RG_PIPE_OCC_EN
        chk("rel_occ", occ, 0);
`endif
        @(posedge clk); #1;

        // latency and throughput
        outs.delete();
        for (int c = 0; c < 8; c++) begin
            cyc(c < 3, lat_d[c], 1, 0);
            chk("lat_ov", s_ov, lat_ov[c]);
        end
        chk("lat_cnt", outs.size(), 3);
        for (int k = 0; k < 3 && k < outs.size(); k++) chk("lat_seq", outs[k], lat_d[k]);

        // fill under backpressure then release
        outs.delete();
        n = 1;
        for (int c = 0; c < 6; c++) begin
            cyc(1, n, 0, 0);
            if (s_acc) n++;
        end
        chk("fill_acc", n, 5);
        chk("fill_ir", in_ready, 0);
        for (int c = 0; c < 30 && outs.size() < 6; c++) begin
            cyc(n <= 6, n, 1, 0);
            if (s_acc) n++;
        end
        chk("bp_cnt", outs.size(), 6);
        for (int k = 0; k < 6 && k < outs.size(); k++) chk("bp_seq", outs[k], k + 1);
        chk("hold_o", o, 6);

        // full pipe with simultaneous in/out
        drain();
        for (int c = 0; c < 4; c++) cyc(1, 40 + c, 0, 0);
        chk("full_q", q.size(), 4);
        for (int c = 0; c < 5; c++) begin
            cyc(1, 50 + c, 1, 0);
            chk("full_in", s_acc, 1);
            chk("full_out", s_ov, 1);
        end
        chk("full_keep", q.size(), 4);

        // flush
        drain();
        cyc(1, 7, 0, 0);
        cyc(1, 8, 0, 0);
        cyc(1, 9, 1, 1);
        chk("fl_acc", s_acc, 0);
        chk("fl_ov", out_valid, 0);
        chk("fl_o", o, 0);
        outs.delete();
        cyc(1, 10, 1, 0);
        cnt = 0;
        while (outs.size() == 0 && cnt < 20) begin
            cyc(0, '0, 1, 0);
            cnt++;
        end
        chk("fl_cnt", outs.size(), 1);
        if (outs.size() > 0) chk("fl_next", outs[0], 10);
        chk("fl_lat", cnt, 4);

        // random traffic with asynchronous reset mid-run
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                in_valid = 0; flush = 0;
                #2 reset = 0;
                #1;
                chk("arst_ov", out_valid, 0);
                q.delete();
                @(posedge clk); #1;
                reset = 1;
                #1;
                chk("arst_ir", in_ready, 1);
                @(posedge clk); #1;
            end
            cyc($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 3) != 0,
                $urandom_range(0, 127) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
